serial_subtractor: RTL and testbench

//   Bit-serial WIDTH-bit subtractor: computes diff = a - b and borrow, one bit per clock, LSB first.

---
 rtl/serial_subtractor_if.sv | 25 ++
 rtl/serial_subtractor.sv | 108 ++++++++++
 tb/tb_serial_subtractor.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The master side issues operands and consumes results; the slave side is the subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow_out, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow_out, busy
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell plus a borrow flop,
// LSB first, with valid/ready handshakes on the operand and result sides.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Full-subtractor cell: returns {borrow_out, difference} for x - y - bin.
  function automatic logic [1:0] fs_cell(input logic x, input logic y, input logic bin);
    fs_cell = {(~x & y) | (~(x ^ y) & bin), x ^ y ^ bin};
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_d_sh;
  logic             r_brw;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow_out;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_d;
  logic             w_brw_next;

  assign {w_brw_next, w_d} = fs_cell(r_a_sh[0], r_b_sh[0], r_brw);

  // Control FSM, serial datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_a_sh       <= '0;
      r_b_sh       <= '0;
      r_d_sh       <= '0;
      r_brw        <= 1'b0;
      r_cnt        <= '0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a_sh     <= bus.a;
            r_b_sh     <= bus.b;
            r_d_sh     <= '0;
            r_brw      <= 1'b0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_d_sh <= {w_d, r_d_sh[WIDTH-1:1]};
          r_brw  <= w_brw_next;
          r_cnt  <= r_cnt + CNT_W'(1);
          // Last bit: the shifted word is complete only with this cycle's difference bit.
          if (r_cnt == LAST_BIT) begin
            r_diff       <= {w_d, r_d_sh[WIDTH-1:1]};
            r_borrow_out <= w_brw_next;
            r_out_valid  <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.diff       = r_diff;
  assign bus.borrow_out = r_borrow_out;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: expected results are queued at operand
// acceptance and checked by independent monitors when a result handshake occurs.
module tb_serial_subtractor;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_err;

  serial_subtractor_if #(.WIDTH(8))  bus8 ();
  serial_subtractor_if #(.WIDTH(16)) bus16 ();

  serial_subtractor #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
  serial_subtractor #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));

  typedef struct {
    logic [8:0] exp;
    int         acc;
    bit         spc;
  } item8_t;

  item8_t      q8[$];
  logic [16:0] q16[$];
  bit          rnd_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Drive one operand pair (called just after a negedge); push the reference result on accept.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input bit keep, input bit spc);
    item8_t it;
    bus8.in_valid = 1'b1;
    bus8.a = a;
    bus8.b = b;
    for (int i = 0; i < 300; i++) begin
      if (bus8.in_ready && !rst) begin
        it.exp = {1'b0, a} - {1'b0, b};
        it.acc = cyc + 1;
        it.spc = spc;
        q8.push_back(it);
        @(negedge clk);
        if (!keep) bus8.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    bus8.in_valid = 1'b0;
    chk("send8_timeout", 32'd1, 32'd0);
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b);
    bus16.in_valid = 1'b1;
    bus16.a = a;
    bus16.b = b;
    for (int i = 0; i < 300; i++) begin
      if (bus16.in_ready && !rst) begin
        q16.push_back({1'b0, a} - {1'b0, b});
        @(negedge clk);
        bus16.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    bus16.in_valid = 1'b0;
    chk("send16_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (q8.size() == 0 && q16.size() == 0 && bus8.in_ready && bus16.in_ready) return;
    end
    chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Result monitor for the 8-bit instance: value, latency, spacing and stall stability.
  initial begin : mon8
    bit         prev_valid;
    int         rise_cyc;
    int         prev_rise;
    logic [8:0] held;
    item8_t     it;
    prev_valid = 1'b0;
    rise_cyc = 0;
    prev_rise = 0;
    held = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (bus8.out_valid && !prev_valid) begin
          rise_cyc = cyc;
          held = {bus8.borrow_out, bus8.diff};
        end else if (bus8.out_valid) begin
          chk("stall_hold", {23'd0, bus8.borrow_out, bus8.diff}, {23'd0, held});
        end
        if (bus8.out_valid && bus8.out_ready) begin
          if (q8.size() == 0) begin
            chk("unexpected_result8", 32'd1, 32'd0);
          end else begin
            it = q8.pop_front();
            chk("result8", {23'd0, bus8.borrow_out, bus8.diff}, {23'd0, it.exp});
            chk("latency8", rise_cyc - it.acc, 32'd8);
            if (it.spc) chk("spacing8", rise_cyc - prev_rise, 32'd10);
            prev_rise = rise_cyc;
          end
        end
        prev_valid = bus8.out_valid;
      end
    end
  end

  // Result monitor for the 16-bit instance.
  initial begin : mon16
    logic [16:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus16.out_valid && bus16.out_ready) begin
        if (q16.size() == 0) begin
          chk("unexpected_result16", 32'd1, 32'd0);
        end else begin
          e = q16.pop_front();
          chk("result16", {15'd0, bus16.borrow_out, bus16.diff}, {15'd0, e});
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] pa [4];
    logic [7:0] pb [4];
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    rnd_done = 1'b0;
    void'($urandom(4045));
    rst = 1'b1;
    bus8.in_valid = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, bus8.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus8.out_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus8.busy}, 32'd0);
    chk("rst_diff", {24'd0, bus8.diff}, 32'd0);
    chk("rst_borrow", {31'd0, bus8.borrow_out}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic and borrow/wrap cases.
    pa = '{8'h05, 8'h03, 8'h00, 8'hFF};
    pb = '{8'h03, 8'h05, 8'h01, 8'hFF};
    for (int i = 0; i < 4; i++) begin
      send8(pa[i], pb[i], 1'b0, 1'b0);
      chk("busy_in_shift", {31'd0, bus8.busy}, 32'd1);
      chk("not_ready_in_shift", {31'd0, bus8.in_ready}, 32'd0);
      wait_idle();
    end

    // Backpressure: hold the result for 5 cycles while ignoring in_valid pulses.
    bus8.out_ready = 1'b0;
    send8(8'h5A, 8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !bus8.out_valid; i++) @(negedge clk);
    chk("stall_out_valid", {31'd0, bus8.out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      bus8.in_valid = 1'b1;
      bus8.a = 8'($urandom);
      bus8.b = 8'($urandom);
      chk("stall_in_ready", {31'd0, bus8.in_ready}, 32'd0);
      @(negedge clk);
    end
    bus8.in_valid = 1'b0;
    bus8.out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", {31'd0, bus8.in_ready}, 32'd1);
    chk("release_out_valid", {31'd0, bus8.out_valid}, 32'd0);
    chk("diff_kept", {24'd0, bus8.diff}, 32'h1E);
    wait_idle();

    // Reset on the 4th SHIFT edge aborts the operation.
    send8(8'h80, 8'h01, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q8.delete();
    chk("abort_in_ready", {31'd0, bus8.in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, bus8.out_valid}, 32'd0);
    chk("abort_diff", {24'd0, bus8.diff}, 32'd0);
    chk("abort_busy", {31'd0, bus8.busy}, 32'd0);
    send8(8'h10, 8'h20, 1'b0, 1'b0);
    wait_idle();

    // Back-to-back with in_valid held and out_ready tied high.
    send8(8'hC4, 8'h21, 1'b1, 1'b0);
    send8(8'h07, 8'h70, 1'b1, 1'b1);
    send8(8'h99, 8'h99, 1'b0, 1'b1);
    wait_idle();

    // Random phase: both widths, with random backpressure on the 8-bit instance.
    fork
      begin
        for (int i = 0; i < 200; i++) send8(8'($urandom), 8'($urandom), 1'b0, 1'b0);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          bus8.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int i = 0; i < 200; i++) send16(16'($urandom), 16'($urandom));
      end
    join
    bus8.out_ready = 1'b1;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
